data_pack_fgh: RTL

- Upstream feeder of the data interconnect stage.
- Accepts one 256-bit AXI-Stream from the DMA and assembles each frame into three word registers: f (1536 b), g (1280 b) and h (256 b).
- Each register drives its own valid/ready output stream into the interconnect's f, g and h inputs.
- Frame layout depends on `mode`: mode 0 is h,g,f (12 beats); mode 1 is h,f (7 beats, no g).

---
 rtl/data_route_pkg.sv | 23 ++
 rtl/seg_pack_reg.sv | 52 +++++
 rtl/data_pack_fgh.sv | 114 +++++++++++
 3 files changed

// File: rtl/data_route_pkg.sv
// Shared widths, segment encoding and per-segment beat counts for the
// DMA-to-interconnect f/g/h packing stage.
package data_route_pkg;
  localparam int DW      = 256;
  localparam int F_BEATS = 6;
  localparam int G_BEATS = 5;
  localparam int H_BEATS = 1;
  localparam int F_W     = DW * F_BEATS;
  localparam int G_W     = DW * G_BEATS;
  localparam int H_W     = DW * H_BEATS;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {SEG_H, SEG_G, SEG_F} seg_t;

  // Index of the final beat of a segment.
  function automatic logic [CNT_W-1:0] seg_last_idx(input seg_t s);
    case (s)
      SEG_H:   return CNT_W'(H_BEATS - 1);
      SEG_G:   return CNT_W'(G_BEATS - 1);
      default: return CNT_W'(F_BEATS - 1);
    endcase
  endfunction
endpackage

// File: rtl/seg_pack_reg.sv
// One output word register: beats are written by index (LSB slice first),
// and a commit raises a valid that holds until the downstream handshake.
module seg_pack_reg
  import data_route_pkg::*;
#(
  parameter int BEATS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [CNT_W-1:0]      wr_idx_i,
  input  logic [DW-1:0]         wr_data_i,
  input  logic                  commit_i,
  output logic                  ready_o,
  output logic [DW*BEATS-1:0]   m_tdata_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i
);
  logic [BEATS-1:0][DW-1:0] data_q;
  logic                     valid_q;
  logic                     valid_d;

  // Data slices carry no reset; they are only meaningful while valid is set.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    always_ff @(posedge clk) begin
      if (wr_en_i && (wr_idx_i == CNT_W'(gi))) begin
        data_q[gi] <= wr_data_i;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (commit_i) begin
      valid_d = 1'b1;
    end else if (valid_q && m_tready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign ready_o    = ~valid_q;
  assign m_tdata_o  = data_q;
  assign m_tvalid_o = valid_q;
endmodule

// File: rtl/data_pack_fgh.sv
// Splits a 256-bit AXI-Stream frame into h, g and f words (mode 0: h,g,f;
// mode 1: h,f), each with an independent valid/ready output.
module data_pack_fgh
  import data_route_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  output logic            s_axis_tready,
  output logic [F_W-1:0]  m_f_tdata,
  output logic            m_f_tvalid,
  input  logic            m_f_tready,
  output logic [G_W-1:0]  m_g_tdata,
  output logic            m_g_tvalid,
  input  logic            m_g_tready,
  output logic [H_W-1:0]  m_h_tdata,
  output logic            m_h_tvalid,
  input  logic            m_h_tready,
  output logic            frame_err
);
  seg_t             seg_q, seg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             commit;
  logic             h_ready, g_ready, f_ready, seg_ready;
  logic             accept, first_beat, mode_eff, last_beat, final_beat;

  always_comb begin
    case (seg_q)
      SEG_G:   seg_ready = g_ready;
      SEG_F:   seg_ready = f_ready;
      default: seg_ready = h_ready;
    endcase
  end

  assign s_axis_tready = seg_ready;
  assign accept        = s_axis_tvalid & seg_ready;
  assign first_beat    = (seg_q == SEG_H) && (cnt_q == '0);
  // The H->? branch is taken on the very beat that latches mode.
  assign mode_eff      = first_beat ? mode : mode_q;
  assign last_beat     = (cnt_q == seg_last_idx(seg_q));
  assign final_beat    = (seg_q == SEG_F) && last_beat;

  always_comb begin
    seg_d  = seg_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    err_d  = 1'b0;
    commit = 1'b0;
    if (accept) begin
      if (first_beat) begin
        mode_d = mode;
      end
      if (final_beat) begin
        commit = 1'b1;
        err_d  = ~s_axis_tlast;
        seg_d  = SEG_H;
        cnt_d  = '0;
      end else if (s_axis_tlast) begin
        // Early tlast: the segment holding the tlast beat is discarded.
        err_d = 1'b1;
        seg_d = SEG_H;
        cnt_d = '0;
      end else if (last_beat) begin
        commit = 1'b1;
        cnt_d  = '0;
        seg_d  = ((seg_q == SEG_H) && !mode_eff) ? SEG_G : SEG_F;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q  <= SEG_H;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      err_q  <= err_d;
    end
  end

  assign frame_err = err_q;

  seg_pack_reg #(.BEATS(H_BEATS)) u_h (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(accept && (seg_q == SEG_H)), .wr_idx_i(cnt_q), .wr_data_i(s_axis_tdata),
    .commit_i(commit && (seg_q == SEG_H)), .ready_o(h_ready),
    .m_tdata_o(m_h_tdata), .m_tvalid_o(m_h_tvalid), .m_tready_i(m_h_tready)
  );

  seg_pack_reg #(.BEATS(G_BEATS)) u_g (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(accept && (seg_q == SEG_G)), .wr_idx_i(cnt_q), .wr_data_i(s_axis_tdata),
    .commit_i(commit && (seg_q == SEG_G)), .ready_o(g_ready),
    .m_tdata_o(m_g_tdata), .m_tvalid_o(m_g_tvalid), .m_tready_i(m_g_tready)
  );

  seg_pack_reg #(.BEATS(F_BEATS)) u_f (
    .clk(clk), .rst_n(rst_n),
    .wr_en_i(accept && (seg_q == SEG_F)), .wr_idx_i(cnt_q), .wr_data_i(s_axis_tdata),
    .commit_i(commit && (seg_q == SEG_F)), .ready_o(f_ready),
    .m_tdata_o(m_f_tdata), .m_tvalid_o(m_f_tvalid), .m_tready_i(m_f_tready)
  );
endmodule
